// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD display path: nibble width, converter FSM
// states and the largest value representable in a given number of digits.
package bcd_pkg;

   localparam int BCD_NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } bcd_state_e;

   // 10^digits - 1, the saturation limit for a display of that many digits.
   function automatic int unsigned bcd_max_value(input int unsigned digits);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < digits; i++) begin
         p = p * 10;
      end
      return p - 1;
   endfunction

endpackage

// File: rtl/bcd_divmod10.sv
// Combinational unsigned divide/modulo by ten, shared by the display blocks.
module bcd_divmod10 import bcd_pkg::*; #(
   parameter int WIDTH = 14
) (
   input  logic [WIDTH-1:0]        value,
   output logic [WIDTH-1:0]        quotient,
   output logic [BCD_NIBBLE_W-1:0] remainder
);

   localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

   always_comb begin
      quotient  = value / TEN;
      // value - 10*q is always 0..9, so only the low nibble carries information.
      remainder = BCD_NIBBLE_W'(value - quotient * TEN);
   end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-packed-BCD converter: one digit per clock through a
// single divide-by-ten unit, with valid/ready handshakes on both sides.
module bcd_convert_ctrl import bcd_pkg::*; #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_binary,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [4*DIGITS-1:0]      packed_bcd,
   output logic                     ovf
);

   localparam int                OUT_W    = BCD_NIBBLE_W * DIGITS;
   localparam int                CNT_W    = $clog2(DIGITS + 1);
   localparam int unsigned       LIMIT    = bcd_max_value(DIGITS);
   localparam logic [WIDTH-1:0]  LIMIT_W  = WIDTH'(LIMIT);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DIGITS - 1);

   bcd_state_e              state_q, state_d;
   logic [WIDTH-1:0]        work_q, work_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [OUT_W-1:0]        res_q, res_d;
   logic                    ovf_q, ovf_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;

   logic [WIDTH-1:0]        quo;
   logic [BCD_NIBBLE_W-1:0] rem;
   logic                    in_over;

   bcd_divmod10 #(.WIDTH(WIDTH)) u_divmod10 (
      .value     (work_q),
      .quotient  (quo),
      .remainder (rem)
   );

   // Compare in a wide domain so a limit larger than the input range never trips.
   assign in_over = 64'(in_binary) > 64'(LIMIT);

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      ovf_d       = ovf_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d    = ST_CONV;
               work_d     = in_over ? LIMIT_W : in_binary;
               ovf_d      = in_over;
               cnt_d      = '0;
               res_d      = '0;
               in_ready_d = 1'b0;
            end
         end
         ST_CONV: begin
            // Units digit comes out first, so digits enter at the top and slide down.
            work_d = quo;
            res_d  = {rem, res_q[OUT_W-1:BCD_NIBBLE_W]};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         work_q      <= '0;
         cnt_q       <= '0;
         res_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign packed_bcd = res_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Self-checking bench for bcd_convert_ctrl: directed scenarios plus a random
// sweep checked against a decimal-string reference model.
module tb_bcd_convert_ctrl;

   localparam int WIDTH  = 14;
   localparam int DIGITS = 4;
   localparam int MAXV   = 9999;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_binary;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       packed_bcd;
   logic              ovf;

   int n_cmp;
   int n_bad;
   int cyc;
   int accept_cyc;

   bcd_convert_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_binary  (in_binary),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .packed_bcd (packed_bcd),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   // Reference: decimal digits of the saturated value, read back as nibbles.
   function automatic logic [15:0] ref_bcd(input int x);
      int          v;
      string       s;
      logic [15:0] r;
      v = (x > MAXV) ? MAXV : x;
      s = $sformatf("%04d", v);
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r = {r[11:0], 4'(s[i] - 8'h30)};
      end
      return r;
   endfunction

   // Present x and hold in_valid until an accept edge; called #1 after an edge.
   task automatic send(input int x);
      int guard;
      in_valid  = 1'b1;
      in_binary = WIDTH'(x);
      guard = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 20) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: got in_ready=%b want 1", in_ready);
      end
      @(posedge clk);
      accept_cyc = cyc;
      #1;
      in_valid = 1'b0;
   endtask

   // Count edges after the accept until out_valid is seen; -1 on timeout.
   task automatic wait_out(output int lat);
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b0; in_binary = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({in_ready, out_valid, packed_bcd, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_state: got rdy=%b vld=%b bcd=%h ovf=%b want 1 0 0000 0",
                  in_ready, out_valid, packed_bcd, ovf);
      end
      // in_valid together with reset must not be accepted
      in_valid = 1'b1; in_binary = WIDTH'(777);
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_vs_valid: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
         end
      end
   endtask

   task automatic test_basic;
      int lat;
      out_ready = 1'b1;
      send(1234);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_early_valid: got %b want 0", out_valid);
      end
      wait_out(lat);
      n_cmp++;
      if (lat != DIGITS) begin
         n_bad++;
         $display("FAIL basic_latency: got %0d want %0d", lat, DIGITS);
      end
      n_cmp++;
      if (packed_bcd !== 16'h1234 || ovf !== 1'b0 || in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_result: got bcd=%h ovf=%b rdy=%b want 1234 0 0", packed_bcd, ovf, in_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || packed_bcd !== 16'h1234) begin
         n_bad++;
         $display("FAIL basic_after_hs: got rdy=%b vld=%b bcd=%h want 1 0 1234", in_ready, out_valid, packed_bcd);
      end
      $display("basic: in=1234 lat=%0d bcd=%h ovf=%b", lat, packed_bcd, ovf);
   endtask

   task automatic test_back_to_back;
      int vals [4] = '{0, 9, 10, 9999};
      int prev;
      int lat;
      out_ready = 1'b1;
      prev = -1;
      foreach (vals[i]) begin
         send(vals[i]);
         if (prev >= 0) begin
            n_cmp++;
            if (accept_cyc - prev != DIGITS + 2) begin
               n_bad++;
               $display("FAIL b2b_interval: got %0d want %0d", accept_cyc - prev, DIGITS + 2);
            end
         end
         prev = accept_cyc;
         wait_out(lat);
         n_cmp++;
         if (lat != DIGITS || packed_bcd !== ref_bcd(vals[i]) || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_result: got lat=%0d bcd=%h ovf=%b want %0d %h 0",
                     lat, packed_bcd, ovf, DIGITS, ref_bcd(vals[i]));
         end
         $display("b2b: in=%0d lat=%0d bcd=%h ovf=%b", vals[i], lat, packed_bcd, ovf);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_saturation;
      int vals [2] = '{10000, 16383};
      int lat;
      out_ready = 1'b1;
      foreach (vals[i]) begin
         send(vals[i]);
         wait_out(lat);
         n_cmp++;
         if (lat != DIGITS || packed_bcd !== 16'h9999 || ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_result: got lat=%0d bcd=%h ovf=%b want %0d 9999 1", lat, packed_bcd, ovf, DIGITS);
         end
         $display("sat: in=%0d lat=%0d bcd=%h ovf=%b", vals[i], lat, packed_bcd, ovf);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall;
      int lat;
      out_ready = 1'b0;
      send(4321);
      wait_out(lat);
      for (int i = 0; i < 10; i++) begin
         in_valid  = i[0];
         in_binary = WIDTH'($urandom_range(0, 16383));
         n_cmp++;
         if (out_valid !== 1'b1 || packed_bcd !== 16'h4321 || ovf !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold: got vld=%b bcd=%h ovf=%b rdy=%b want 1 4321 0 0",
                     out_valid, packed_bcd, ovf, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || packed_bcd !== 16'h4321) begin
         n_bad++;
         $display("FAIL stall_release: got vld=%b rdy=%b bcd=%h want 0 1 4321", out_valid, in_ready, packed_bcd);
      end
      $display("stall: in=4321 lat=%0d bcd=%h", lat, packed_bcd);
   endtask

   task automatic test_reset_mid;
      int lat;
      out_ready = 1'b1;
      send(5678);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || packed_bcd !== 16'h0000 || in_ready !== 1'b1 || ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_state: got vld=%b bcd=%h rdy=%b ovf=%b want 0 0000 1 0",
                  out_valid, packed_bcd, in_ready, ovf);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_no_pulse: got %b want 0", out_valid);
         end
      end
      send(42);
      wait_out(lat);
      n_cmp++;
      if (lat != DIGITS || packed_bcd !== 16'h0042 || ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_next: got lat=%0d bcd=%h ovf=%b want %0d 0042 0", lat, packed_bcd, ovf, DIGITS);
      end
      $display("midreset: next in=42 bcd=%h", packed_bcd);
      @(posedge clk); #1;
   endtask

   task automatic test_random_sweep;
      int x;
      int lat;
      int bad_nib;
      out_ready = 1'b1;
      for (int k = 0; k < 1200; k++) begin
         case (k)
            0: x = 0;
            1: x = 9999;
            2: x = 10000;
            3: x = 16383;
            default: x = $urandom_range(0, 16383);
         endcase
         send(x);
         wait_out(lat);
         bad_nib = 0;
         for (int d = 0; d < 4; d++) begin
            if (((packed_bcd >> (4 * d)) & 16'hF) > 9) bad_nib++;
         end
         n_cmp++;
         if (lat != DIGITS || bad_nib != 0 || packed_bcd !== ref_bcd(x) || ovf !== (x > MAXV)) begin
            n_bad++;
            $display("FAIL sweep: in=%0d got lat=%0d bcd=%h ovf=%b want %0d %h %b",
                     x, lat, packed_bcd, ovf, DIGITS, ref_bcd(x), (x > MAXV));
         end
         if (k < 8) $display("sweep: in=%0d bcd=%h ovf=%b", x, packed_bcd, ovf);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      accept_cyc = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_saturation();
      test_stall();
      test_reset_mid();
      test_random_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
